// File: rtl/mips_io_pkg.sv
// Shared constants and helpers for the mips_mem memory-mapped output port.
// Contents:
//   WORD_WIDTH       default bus width of the mips data path
//   IO_ADDR_DEFAULT  store address that feeds the output FIFO
//   CLR_ADDR_DEFAULT store address that clears the sticky overflow state
//   mips_word_t      one bus word
//   ptr_width()      FIFO pointer width: index bits plus one wrap bit
package mips_io_pkg;

  localparam int unsigned WORD_WIDTH = 8;

  localparam logic [WORD_WIDTH-1:0] IO_ADDR_DEFAULT  = 8'hFF;
  localparam logic [WORD_WIDTH-1:0] CLR_ADDR_DEFAULT = 8'hFE;

  typedef logic [WORD_WIDTH-1:0] mips_word_t;

  // The extra MSB distinguishes full from empty when the indices match.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mips_io_fifo.sv
// Show-ahead synchronous FIFO (DEPTH x WIDTH) for the mips output port.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset; discards all contents
//   push   in   write wdata at the clock edge (ignored while full)
//   wdata  in   entry to write
//   pop    in   advance the head at the clock edge (ignored while empty)
//   rdata  out  head entry, forced to zero while empty
//   empty  out  no entries held
//   full   out  DEPTH entries held
module mips_io_fifo
  import mips_io_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Masking with empty gives a zero head after reset without clearing the array.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer registers; wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mips_io_port.sv
// Memory-mapped output port snooping the mips_mem store bus.
// Stores to IO_ADDR are queued in a FIFO and drained over valid/ready;
// stores to a full FIFO are dropped and set a sticky overflow flag,
// which a store to CLR_ADDR clears (a same-cycle drop wins).
// Optional feature macro: MIPS_IO_DROP_CNT_EN adds a saturating drop_count.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   memwrite    in   CPU store strobe
//   adr         in   CPU store address
//   writedata   in   CPU store data
//   out_data    out  FIFO head, zero while out_valid=0
//   out_valid   out  FIFO not empty
//   out_ready   in   consumer accepts out_data this cycle
//   full        out  FIFO holds DEPTH entries
//   overflow    out  sticky: a store to IO_ADDR was dropped
//   drop_count  out  (MIPS_IO_DROP_CNT_EN only) saturating dropped-store count
module mips_io_port
  import mips_io_pkg::*;
#(
  parameter int unsigned      WIDTH    = WORD_WIDTH,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] IO_ADDR  = WIDTH'(IO_ADDR_DEFAULT),
  parameter logic [WIDTH-1:0] CLR_ADDR = WIDTH'(CLR_ADDR_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic             overflow
`ifdef MIPS_IO_DROP_CNT_EN
  ,
  output logic [WIDTH-1:0] drop_count
`endif
);

  logic io_store;
  logic clr_store;
  logic push;
  logic drop;
  logic pop;
  logic empty;

  // Address decode; full is the registered pre-pop state, so a drop
  // happens even when the consumer frees a slot in the same cycle.
  assign io_store  = memwrite && (adr == IO_ADDR);
  assign clr_store = memwrite && (adr == CLR_ADDR);
  assign push      = io_store & ~full;
  assign drop      = io_store & full;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  mips_io_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (writedata),
    .pop   (pop),
    .rdata (out_data),
    .empty (empty),
    .full  (full)
  );

  // Sticky overflow flag; drop has priority over clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_store) begin
      overflow <= 1'b0;
    end
  end

`ifdef MIPS_IO_DROP_CNT_EN
  // Saturating drop counter; a drop coinciding with a clear restarts at one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop) begin
      if (clr_store) begin
        drop_count <= WIDTH'(1);
      end else if (drop_count != '1) begin
        drop_count <= drop_count + WIDTH'(1);
      end
    end else if (clr_store) begin
      drop_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_mips_io_port.sv
// Directed self-checking bench for mips_io_port (WIDTH=8, DEPTH=4).
module tb_mips_io_port;

  logic       clk;
  logic       reset;
  logic       memwrite;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       full;
  logic       overflow;
`ifdef MIPS_IO_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  mips_io_port dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .overflow  (overflow)
`ifdef MIPS_IO_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle store; returns 1 time unit after the capturing edge.
  task automatic store(input logic [7:0] a, input logic [7:0] d);
    memwrite  = 1'b1;
    adr       = a;
    writedata = d;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  // Check head then accept it with a one-cycle ready pulse.
  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    memwrite  = 1'b0;
    adr       = 8'h00;
    writedata = 8'h00;
    out_ready = 1'b0;
    reset     = 1'b0;

    // 1: reset held with an active store to IO_ADDR
    memwrite  = 1'b1;
    adr       = 8'hFF;
    writedata = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
    end
    check("rst_data", 32'(out_data), 32'd0);
    memwrite = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // 2: single store, held while stalled, then one pop
    store(8'hFF, 8'h0D);
    for (int i = 0; i < 5; i++) begin
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_data", 32'(out_data), 32'h0D);
      @(posedge clk);
      #1;
    end
    pop_expect("single_pop", 8'h0D);
    check("single_empty", 32'(out_valid), 32'd0);

    // 3: fill to full, then one dropped store
    for (int i = 1; i <= 4; i++) begin
      store(8'hFF, 8'(i));
      check("fill_full", 32'(full), (i == 4) ? 32'd1 : 32'd0);
      check("fill_ovf", 32'(overflow), 32'd0);
    end
    store(8'hFF, 8'h05);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_full", 32'(full), 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect("drain", 8'(i));
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);

    // 5: clear overflow, ordinary address ignored
    store(8'h10, 8'h99);
    check("other_addr_valid", 32'(out_valid), 32'd0);
    check("other_addr_ovf", 32'(overflow), 32'd1);
    store(8'hFE, 8'h3C);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_no_push", 32'(out_valid), 32'd0);

    // full store with a same-cycle pop still drops (full sampled before pop)
    for (int i = 0; i < 4; i++) store(8'hFF, 8'(8'h20 + i));
    check("refill_full", 32'(full), 32'd1);
    out_ready = 1'b1;
    store(8'hFF, 8'h2F);
    out_ready = 1'b0;
    check("drop_pop_ovf", 32'(overflow), 32'd1);
    check("drop_pop_full", 32'(full), 32'd0);
    for (int i = 1; i < 4; i++) pop_expect("drop_pop_drain", 8'(8'h20 + i));
    check("drop_pop_empty", 32'(out_valid), 32'd0);
    store(8'hFE, 8'h00);
    check("clr2_ovf", 32'(overflow), 32'd0);

    // 4: concurrent push+pop with two entries queued
    store(8'hFF, 8'h0A);
    store(8'hFF, 8'h0B);
    out_ready = 1'b1;
    store(8'hFF, 8'h07);
    out_ready = 1'b0;
    check("conc_head", 32'(out_data), 32'h0B);
    check("conc_full", 32'(full), 32'd0);
    pop_expect("conc_pop1", 8'h0B);
    pop_expect("conc_pop2", 8'h07);
    check("conc_empty", 32'(out_valid), 32'd0);

    // pointer wrap: 3*DEPTH push/pop pairs
    for (int i = 0; i < 12; i++) begin
      store(8'hFF, 8'(8'h40 + i));
      pop_expect("wrap", 8'(8'h40 + i));
    end
    check("wrap_empty", 32'(out_valid), 32'd0);
    check("wrap_ovf", 32'(overflow), 32'd0);

    // 6: mid-operation reset during a stalled, overflowed transfer
    for (int i = 0; i < 4; i++) store(8'hFF, 8'(8'h50 + i));
    store(8'hFF, 8'h5F);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    check("pre_rst_head", 32'(out_data), 32'h50);
    out_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    #1;
    reset     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("post_mid_valid", 32'(out_valid), 32'd0);
    store(8'hFF, 8'h77);
    check("post_mid_data", 32'(out_data), 32'h77);
    pop_expect("post_mid_pop", 8'h77);
    check("post_mid_empty", 32'(out_valid), 32'd0);

`ifdef MIPS_IO_DROP_CNT_EN
    check("cnt_reset", 32'(drop_count), 32'd0);
    for (int i = 0; i < 4; i++) store(8'hFF, 8'(i));
    for (int i = 0; i < 3; i++) store(8'hFF, 8'hEE);
    check("cnt_three", 32'(drop_count), 32'd3);
    store(8'hFE, 8'h00);
    check("cnt_clear", 32'(drop_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
